// File: rtl/seq_hamming_unit.sv
// ---------------------------------------------------------------------------
// seq_hamming_unit
//
// Multi-cycle Hamming weight / Hamming distance unit.  An operand word of
// DATA_W bits is counted SLICE_W bits per clock, so the adder logic scales
// with SLICE_W instead of DATA_W.  MODE=0 counts the set bits of A; MODE=1
// counts the set bits of A^B (the distance between A and B).
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   rst        - synchronous active-high reset, dominates all other inputs
//   in_valid   - A, B and MODE are valid
//   in_ready   - unit is idle and will accept operands this cycle
//   MODE       - 0: weight of A, 1: distance between A and B
//   A, B       - operands (B ignored when MODE=0)
//   out_valid  - RESULT is valid, held until out_ready is seen
//   out_ready  - consumer accepts RESULT
//   RESULT     - number of set bits, 0..DATA_W
// ---------------------------------------------------------------------------
module seq_hamming_unit #(
  parameter int DATA_W  = 64,
  parameter int SLICE_W = 8,
  parameter int RES_W   = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              MODE,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  RESULT
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  // Width of a single-slice count: holds 0..SLICE_W exactly.
  localparam int SC_W   = $clog2(SLICE_W + 1);
  // Adder tree leaf count, rounded up to a power of two; extra leaves are 0.
  localparam int TREE_N = 1 << $clog2(SLICE_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [RES_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                out_valid_q, out_valid_d;

  logic [SC_W-1:0]     slice_cnt;
  logic [RES_W-1:0]    slice_sum;

  // Binary adder tree over one slice.  Every node is SC_W bits wide, which
  // already holds the largest possible subtree sum, so nothing is truncated.
  // node[1] is the root; node[TREE_N + i] is leaf i.
  function automatic logic [SC_W-1:0] slice_popcount(input logic [SLICE_W-1:0] s);
    logic [SC_W-1:0] node [1:2*TREE_N-1];
    for (int i = 0; i < TREE_N; i++) begin
      node[TREE_N + i] = '0;
    end
    for (int i = 0; i < SLICE_W; i++) begin
      node[TREE_N + i] = SC_W'(s[i]);
    end
    for (int i = TREE_N - 1; i >= 1; i--) begin
      node[i] = node[2*i] + node[2*i + 1];
    end
    return node[1];
  endfunction

  // The low slice of the work register is always the next one to count.
  assign slice_cnt = slice_popcount(work_q[SLICE_W-1:0]);
  assign slice_sum = acc_q + RES_W'(slice_cnt);

  // Next-state logic for the whole unit.  Operands are captured only on the
  // IDLE accept edge; BUSY shifts one slice out per cycle and the final
  // running sum lands in RESULT as the FSM enters DONE.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = MODE ? (A ^ B) : A;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        acc_d  = slice_sum;
        work_d = work_q >> SLICE_W;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NSLICE - 1)) begin
          result_d    = slice_sum;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // All state lives here; reset wins over any handshake in the same cycle
  // and discards any partially counted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign RESULT    = result_q;

endmodule
